// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_e : fetch FSM state encoding
//   - npc_sel_e     : next-PC source select used by if_next_pc
//   - NOP_INST_C    : bubble instruction (addi x0,x0,0)
//   - PC_INCR       : sequential PC step
//   - ALIGN_MASK    : clears the byte-offset bits of a word address
//   - word_align()  : applies ALIGN_MASK to an address
// Optional feature macro used by the importing files: FETCH_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    NPC_HOLD  = 2'd0,
    NPC_SEQ   = 2'd1,
    NPC_REDIR = 2'd2
  } npc_sel_e;

  localparam logic [31:0] NOP_INST_C = 32'h0000_0013;
  localparam logic [31:0] PC_INCR    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// -----------------------------------------------------------------------------
// if_next_pc
// Combinational next-fetch-address mux for the fetch stage.
//   sel_i         : NPC_HOLD keeps fetch_pc_i, NPC_SEQ adds 4 (32-bit wrap),
//                   NPC_REDIR takes the redirect target
//   fetch_pc_i    : current fetch address
//   redirect_pc_i : redirect target from EXE (may carry non-zero low bits)
//   next_pc_o     : next fetch address, always word aligned
// Optional feature (macro FETCH_MISALIGN_TRAP_EN): a misaligned redirect target
// is replaced by TRAP_PC. Without the macro the low two bits are dropped.
// -----------------------------------------------------------------------------
module if_next_pc
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] TRAP_PC = 32'h0000_0100
) (
  input  npc_sel_e    sel_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] target_aligned;
  logic [31:0] trap_aligned;
  logic        trap_take;

  assign target_aligned = word_align(redirect_pc_i);
  assign trap_aligned   = word_align(TRAP_PC);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap_take = |redirect_pc_i[1:0];
`else
  assign trap_take = 1'b0;
`endif

  always_comb begin
    next_pc_o = fetch_pc_i;
    unique case (sel_i)
      NPC_HOLD:  next_pc_o = fetch_pc_i;
      NPC_SEQ:   next_pc_o = fetch_pc_i + PC_INCR;
      NPC_REDIR: next_pc_o = trap_take ? trap_aligned : target_aligned;
      default:   next_pc_o = fetch_pc_i;
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the PC, issues synchronous instruction-memory
// reads and hands one instruction (or a NOP bubble) per cycle to IF/EXE.
//
// Ports
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   stall_i          : downstream hold; current inst/pc stay, no new fetch
//   redirect_i       : one-cycle taken branch/jump pulse from EXE
//   redirect_pc_i    : redirect target
//   imem_req_o       : instruction-memory read enable
//   imem_addr_o      : word-aligned read address
//   imem_rdata_i     : read data, valid the cycle after an accepted request
//   inst_o, pc_o     : instruction and its PC towards IF/EXE
//   inst_valid_o     : 1 = inst_o is real, 0 = bubble
//   misalign_o       : misaligned-redirect pulse (0 unless the feature is built)
//
// Output semantics: inst_o/pc_o are meaningful whenever inst_valid_o=1; the
// downstream consumes them on a cycle with inst_valid_o=1 and stall_i=0, and
// while stall_i=1 the same instruction and PC are presented unchanged.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets
// trap to TRAP_PC and pulse misalign_o for the bubble cycle).
// -----------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_C,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;   // address of the next request
  logic [31:0]  issued_pc_q, issued_pc_d; // address of the request in flight
  logic [31:0]  hold_inst_q, hold_inst_d; // instruction parked during a stall

  npc_sel_e     npc_sel;
  logic         issue;
  logic         capture;
  logic [31:0]  inst_c;
  logic         valid_c;

  if_next_pc #(
    .TRAP_PC (TRAP_PC)
  ) u_next_pc (
    .sel_i         (npc_sel),
    .fetch_pc_i    (fetch_pc_q),
    .redirect_pc_i (redirect_pc_i),
    .next_pc_o     (fetch_pc_d)
  );

  // Next-state and output decode. A redirect overrides whatever the current
  // state chose: the sequential fetch in flight is abandoned and the target
  // becomes the next request, even if stall_i is high in the same cycle.
  always_comb begin
    state_d = state_q;
    npc_sel = NPC_HOLD;
    issue   = 1'b0;
    capture = 1'b0;
    inst_c  = NOP_INST;
    valid_c = 1'b0;

    unique case (state_q)
      BOOT: begin
        issue   = 1'b1;
        npc_sel = NPC_SEQ;
        state_d = RUN;
      end
      RUN: begin
        inst_c  = imem_rdata_i;
        valid_c = 1'b1;
        if (stall_i) begin
          // The word arriving now is the one being presented; park it, since
          // the memory will not repeat it. fetch_pc does not advance so the
          // request abandoned here is re-issued on release.
          capture = 1'b1;
          state_d = STALL;
        end else begin
          issue   = 1'b1;
          npc_sel = NPC_SEQ;
        end
      end
      STALL: begin
        inst_c  = hold_inst_q;
        valid_c = 1'b1;
        if (!stall_i) begin
          // Present the parked word one last time while re-fetching, so the
          // memory data lines up with RUN on the next cycle.
          issue   = 1'b1;
          npc_sel = NPC_SEQ;
          state_d = RUN;
        end
      end
      FLUSH: begin
        // Target request goes out now; stall_i is only looked at from RUN.
        issue   = 1'b1;
        npc_sel = NPC_SEQ;
        state_d = RUN;
      end
    endcase

    if (redirect_i) begin
      npc_sel = NPC_REDIR;
      capture = 1'b0;
      state_d = FLUSH;
    end
  end

  assign issued_pc_d = issue   ? fetch_pc_q   : issued_pc_q;
  assign hold_inst_d = capture ? imem_rdata_i : hold_inst_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      fetch_pc_q  <= word_align(RESET_PC);
      issued_pc_q <= RESET_PC;
      hold_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // BOOT is also the reset state, but no request may leave while rst_n is
  // still low, hence the gate.
  assign imem_req_o   = issue & rst_n;
  assign imem_addr_o  = word_align(fetch_pc_q);
  assign inst_o       = inst_c;
  assign pc_o         = issued_pc_q;
  assign inst_valid_o = valid_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  // High for exactly the bubble cycle that follows a misaligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_i & (|redirect_pc_i[1:0]);
    end
  end

  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Bench for if_fetch_stage. Instruction memory returns addr>>2 one cycle after
// a request (a fixed garbage word when no request was made). The reference
// model describes the delivered program flow: consecutive words from RESET_PC,
// a redirect makes the target the next real instruction after one bubble, a
// stall keeps presenting the not-yet-consumed instruction.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0100;
  localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;
  logic        misalign_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_valid_o  (inst_valid_o),
    .misalign_o    (misalign_o)
  );

  // Synchronous instruction memory.
  always @(posedge clk) begin
    imem_rdata_i <= imem_req_o ? (imem_addr_o >> 2) : GARBAGE;
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        valid;
    logic        chk_req;
    logic        req;
    logic        chk_addr;
    logic        misal;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  bit          m_boot;
  bit          m_prev_redir;
  bit          m_prev_misal;
  logic [31:0] m_next_pc;   // PC of the next instruction the consumer should see
  logic [31:0] m_redir_tgt; // where the bubble cycle must fetch from

  function automatic logic [31:0] map_target(input logic [31:0] tgt);
    if (TRAP_EN && (tgt[1:0] != 2'b00)) return TRAP_PC;
    return {tgt[31:2], 2'b00};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; drives one cycle of inputs, records what the DUT must
  // show during that cycle, then advances to the next posedge+1.
  task automatic drive_cycle(input bit s, input bit r, input logic [31:0] tgt);
    exp_t e;
    stall_i       = s;
    redirect_i    = r;
    redirect_pc_i = r ? tgt : $urandom();
    e          = '0;
    e.valid    = !m_boot && !m_prev_redir;
    e.pc       = m_next_pc;
    e.inst     = m_next_pc >> 2;
    e.chk_req  = !r;
    e.req      = !(s && e.valid);
    e.chk_addr = m_boot || m_prev_redir;
    e.addr     = m_prev_redir ? m_redir_tgt : RESET_PC;
    e.misal    = m_prev_misal;
    exp_q.push_back(e);

    if (e.valid && !s) m_next_pc = m_next_pc + 32'd4;
    if (r) begin
      m_next_pc    = map_target(tgt);
      m_redir_tgt  = map_target(tgt);
      m_prev_misal = TRAP_EN && (tgt[1:0] != 2'b00);
    end else begin
      m_prev_misal = 1'b0;
    end
    m_prev_redir = r;
    m_boot       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic check_reset_values();
    check("rst_pc", pc_o, RESET_PC);
    check("rst_inst", inst_o, NOP_INST);
    check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_misalign", {31'b0, misalign_o}, 32'd0);
  endtask

  // Asserts reset from wherever the run is (posedge+1), checks that outputs
  // dropped before any clock edge, then releases it at posedge+1.
  task automatic do_reset();
    rst_n      = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    #2;
    check_reset_values();
    @(posedge clk);
    #1;
    check_reset_values();
    rst_n        = 1'b1;
    m_boot       = 1'b1;
    m_prev_redir = 1'b0;
    m_prev_misal = 1'b0;
    m_next_pc    = RESET_PC;
    m_redir_tgt  = RESET_PC;
  endtask

  function automatic logic [31:0] random_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = $urandom() & 32'h0000_FFFC;
      1:       t = $urandom();
      2:       t = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      default: t = 32'h0000_0040 | 32'($urandom_range(1, 3));
    endcase
    return t;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid", {31'b0, inst_valid_o}, {31'b0, e.valid});
      if (e.valid) begin
        check("pc", pc_o, e.pc);
        check("inst", inst_o, e.inst);
      end
      if (e.chk_req) check("req", {31'b0, imem_req_o}, {31'b0, e.req});
      if (e.chk_addr) check("addr", imem_addr_o, e.addr);
      if (imem_req_o) check("addr_align", {30'b0, imem_addr_o[1:0]}, 32'd0);
      check("misalign", {31'b0, misalign_o}, {31'b0, e.misal});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;

    // Reset release: boot cycle, then pc 0, 4, 8; stall three cycles on pc 8.
    do_reset();
    idle_cycles(3);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 32'h0);
    idle_cycles(2);
    // Redirect to 0x40.
    drive_cycle(1'b0, 1'b1, 32'h0000_0040);
    idle_cycles(3);
    // Redirect and stall together: flush wins.
    drive_cycle(1'b1, 1'b1, 32'h0000_0080);
    drive_cycle(1'b1, 1'b0, 32'h0);
    idle_cycles(3);
    // Wrap through the top of the address space.
    drive_cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    idle_cycles(4);
    // Misaligned target.
    drive_cycle(1'b0, 1'b1, 32'h0000_0042);
    idle_cycles(3);
    // Redirect during a stall, then back-to-back redirects.
    drive_cycle(1'b1, 1'b0, 32'h0);
    drive_cycle(1'b1, 1'b1, 32'h0000_0200);
    drive_cycle(1'b0, 1'b1, 32'h0000_0301);
    idle_cycles(3);

    // Redirect in the boot cycle.
    do_reset();
    drive_cycle(1'b0, 1'b1, 32'h0000_0500);
    idle_cycles(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit s;
      bit r;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      drive_cycle(s, r, random_target());
    end

    // Reset asserted in the middle of a stall.
    idle_cycles(2);
    drive_cycle(1'b1, 1'b0, 32'h0);
    drive_cycle(1'b1, 1'b0, 32'h0);
    do_reset();
    idle_cycles(4);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
